// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, reset address and nop encoding for the fetch stage.
package fetch_stage_pkg;
  localparam int PC_WIDTH = 12;
  localparam int INSN_WIDTH = 32;
  localparam int RESET_PC = 0;
  localparam logic [INSN_WIDTH-1:0] NOP_INSN = 32'h0;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives imem, and fills the F/D slot through a one-entry stall buffer.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int PC_WIDTH = fetch_stage_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(fetch_stage_pkg::RESET_PC)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INSN_WIDTH-1:0] imem_q,
  output logic                  fd_valid,
  output logic [INSN_WIDTH-1:0] fd_insn,
  output logic [PC_WIDTH-1:0]   fd_pc
);
  logic [PC_WIDTH-1:0] pc_q, req_pc_q, hold_pc_q, src_pc;
  logic [INSN_WIDTH-1:0] hold_insn_q, src_insn;
  logic req_valid_q, hold_valid_q, src_valid;
  assign imem_addr = pc_q;
  // A held instruction is older than anything on imem_q, so it drains first.
  always_comb begin
    src_valid = hold_valid_q | req_valid_q;
    src_insn = hold_valid_q ? hold_insn_q : imem_q;
    src_pc = hold_valid_q ? hold_pc_q : req_pc_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q <= '0;
      hold_valid_q <= 1'b0;
      hold_insn_q <= NOP_INSN;
      hold_pc_q <= '0;
      fd_valid <= 1'b0;
      fd_insn <= NOP_INSN;
      fd_pc <= '0;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
      req_valid_q <= 1'b0;
      hold_valid_q <= 1'b0;
      fd_valid <= 1'b0;
      fd_insn <= NOP_INSN;
    end else if (stall) begin
      req_valid_q <= 1'b0;
      if (req_valid_q && !hold_valid_q) begin
        hold_valid_q <= 1'b1;
        hold_insn_q <= imem_q;
        hold_pc_q <= req_pc_q;
      end
    end else begin
      fd_valid <= src_valid;
      fd_insn <= src_valid ? src_insn : NOP_INSN;
      if (src_valid) fd_pc <= src_pc + PC_WIDTH'(1);
      hold_valid_q <= 1'b0;
      req_valid_q <= 1'b1;
      req_pc_q <= pc_q;
      pc_q <= pc_q + PC_WIDTH'(1);
    end
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: owns the program counter, issues word addresses to the synchronous instruction memory, and delivers `{insn, pc+1}` to the F/D boundary. It is the receiving end of the execute stage's redirect outputs (selected branch/jump target) and the source of the `pc` value execute uses for `pc + immediate` branch arithmetic. It stalls on decode hazards and flushes in-flight fetches on redirect.

## Interface
- `PC_WIDTH`, 12, instruction-memory word-address width.
- `RESET_PC`, 0, first fetch address after reset.
- `clock` in 1 — single clock, all state on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `stall` in 1 — decode hazard; hold F/D outputs and PC.
- `redirect_valid` in 1 — taken branch/jump from execute this cycle.
- `redirect_pc` in PC_WIDTH — target (execute's selected branch_pc or jump_pc).
- `imem_addr` out PC_WIDTH — address to imem; equals internal `pc_q`.
- `imem_q` in 32 — imem data, valid one cycle after the address is presented.
- `fd_valid` out 1 — F/D slot holds a real instruction.
- `fd_insn` out 32 — fetched instruction; 0 (nop) when `fd_valid`=0.
- `fd_pc` out PC_WIDTH — address of `fd_insn` plus 1, modulo 2^PC_WIDTH.

## Operation
- State: `pc_q`, `req_valid_q`/`req_pc_q` (request in flight, data on `imem_q` this cycle), one-entry hold buffer `hold_valid_q`/`hold_insn_q`/`hold_pc_q`, registered `fd_*`.
- Priority per edge: reset > redirect > stall > normal.
- Redirect: `pc_q`←`redirect_pc`; `req_valid_q`←0; `hold_valid_q`←0; `fd_valid`←0, `fd_insn`←0 (bubble); `fd_pc` unchanged. Redirect overrides a simultaneous stall.
- Stall: `fd_*` and `pc_q` hold; `req_valid_q`←0 (no new request). If `req_valid_q`=1 and `hold_valid_q`=0, capture `imem_q`/`req_pc_q` into hold. Stall of any length loses no instruction.
- Normal: source = hold if `hold_valid_q`, else `imem_q`/`req_pc_q` if `req_valid_q`, else none. `fd_valid`←source present; `fd_insn`←source insn or 0; `fd_pc`←source pc+1. `hold_valid_q`←0; `req_valid_q`←1; `req_pc_q`←`pc_q`; `pc_q`←`pc_q`+1.
- Arithmetic: all PC adds are PC_WIDTH-bit unsigned, wrap 4095→0 silently; no fault.

## Timing
- Reset (async assert, sync-safe deassert): `pc_q`=RESET_PC, `imem_addr`=RESET_PC, `req_valid_q`=0, `hold_valid_q`=0, `fd_valid`=0, `fd_insn`=0, `fd_pc`=0.
- After deassert: edge 1 issues RESET_PC; edge 2 `fd_valid`=1 with insn@RESET_PC, `fd_pc`=RESET_PC+1. Steady throughput one insn/cycle.
- Redirect latency: redirect sampled at edge E → `imem_addr`=target after E; target insn in `fd_*` after E+2; exactly two bubbles (after E and E+1) unless stalled.
- Stall release: instruction held in buffer appears at the first unstalled edge; next instruction follows at the next edge, no bubble.
- Reset mid-stall or mid-redirect discards all in-flight and held state.

## Structure
- Shared package: `PC_WIDTH`, `INSN_WIDTH`=32, `RESET_PC`, `NOP_INSN`=32'h0.
- Single module; no sub-module. The +1 incrementers are inline PC_WIDTH-bit adds, kept separate from the execute-stage 32-bit adder.

## Test plan
- Reset release, imem word k = 32'hA000_0000+k → `fd_valid` rises at edge 2 with insn A000_0000, `fd_pc`=1; then A000_0001/`fd_pc`=2, etc.
- Stall 3 cycles while fd holds insn@5 → `fd_*` frozen at insn@5 for 3 cycles; on release insn@6 then insn@7 on consecutive edges, none lost or duplicated.
- Redirect to 12'h100 while fetching 20 → fd shows two bubbles (`fd_valid`=0, `fd_insn`=0), then insn@0x100, `fd_pc`=0x101.
- Redirect and stall together, target 12'h040 → redirect wins; hold cleared; insn@0x040 after two edges.
- `pc_q` reaching 12'hFFF → insn@0xFFF with `fd_pc`=0, next insn@0x000.
- `reset_n` asserted mid-stall with hold full → all outputs 0 immediately; restart fetches from RESET_PC.
